vga_vram_arbiter: RTL

Scan-out controller and single-port video-RAM arbiter for the POS display path. Sits between `vgasync` (640x480 timing, 800x525 total, `p_tick` pixel enable) and one external single-port synchronous RAM holding a 160x120, 8-bit RGB332 frame buffer (each stored pixel covers 4x4 screen pixels). It prefetches frame-buffer bytes ahead of the beam with absolute priority and gives all remaining RAM cycles to one write requester (POS logic). It drives 8-bit-per-channel RGB plus delay-matched syncs.

---
 rtl/vga_vram_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_vram_arbiter.sv
// Scan-out controller and single-port video-RAM arbiter: prefetches one RGB332
// frame-buffer byte per 4x4 screen cell ahead of the beam and lends spare RAM cycles to one writer.
module vga_vram_arbiter #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [8:0]  CELLS_PER_LINE = 9'd200;
  localparam logic [9:0]  Y_LAST         = 10'd524;
  localparam logic [8:0]  FB_W_C         = 9'(FB_W);
  localparam logic [7:0]  FB_H_C         = 8'(FB_H);
  localparam logic [14:0] FB_W_A         = 15'(FB_W);
  localparam logic [14:0] FB_SIZE        = 15'(FB_W * FB_H);

  logic        trig, advance, fetch_ok;
  logic [8:0]  n_cell;
  logic [9:0]  y_tgt;
  logic [7:0]  row;
  logic [14:0] cell_addr;

  logic        fetch_pend_q, fetch_pend_d;
  logic [14:0] fetch_addr_q, fetch_addr_d;
  logic        rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d;
  logic [7:0]  next_pix_q, next_pix_d, cur_pix_q, cur_pix_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q;
  logic        grant_rd, grant_wr, wr_bad;

  // Prefetch target: the cell after the current one, wrapping to cell 0 of the next line.
  always_comb begin
    trig    = p_tick && (x[1:0] == 2'b01);
    advance = p_tick && (x[1:0] == 2'b11);
    n_cell  = {1'b0, x[9:2]} + 9'd1;
    y_tgt   = y;
    if (n_cell == CELLS_PER_LINE) begin
      n_cell = '0;
      y_tgt  = (y == Y_LAST) ? '0 : y + 10'd1;
    end
    row       = y_tgt[9:2];
    fetch_ok  = (n_cell < FB_W_C) && (row < FB_H_C);
    cell_addr = 15'(row) * FB_W_A + 15'(n_cell);
  end

  // Write handshake: wr_req with wr_addr/wr_data held stable until a one-cycle
  // wr_ack; grant is withheld while wr_ack is high so a held request is taken once.
  always_comb begin
    grant_rd     = fetch_pend_q;
    grant_wr     = !fetch_pend_q && wr_req && !wr_ack_q;
    wr_bad       = (wr_addr >= FB_SIZE);
    fetch_pend_d = fetch_pend_q;
    fetch_addr_d = fetch_addr_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    wr_ack_d     = 1'b0;
    wr_err_d     = 1'b0;
    rd_v1_d      = grant_rd;
    rd_v2_d      = rd_v1_q;
    next_pix_d   = next_pix_q;
    cur_pix_d    = advance ? next_pix_q : cur_pix_q;

    if (grant_rd) begin
      ram_addr_d   = fetch_addr_q;
      fetch_pend_d = 1'b0;
    end else if (grant_wr) begin
      ram_addr_d  = wr_addr;
      ram_we_d    = !wr_bad;
      ram_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
      wr_err_d    = wr_bad;
    end

    if (trig) begin
      if (fetch_ok) begin
        fetch_pend_d = 1'b1;
        fetch_addr_d = cell_addr;
      end else begin
        next_pix_d = '0;
      end
    end
    if (rd_v2_q) next_pix_d = ram_rdata;

    rgb_d = '0;
    if (video_on)
      rgb_d = {cur_pix_q[7:5], cur_pix_q[7:5], cur_pix_q[7:6],
               cur_pix_q[4:2], cur_pix_q[4:2], cur_pix_q[4:3],
               {4{cur_pix_q[1:0]}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pend_q <= 1'b0;
      fetch_addr_q <= '0;
      rd_v1_q      <= 1'b0;
      rd_v2_q      <= 1'b0;
      next_pix_q   <= '0;
      cur_pix_q    <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      fetch_pend_q <= fetch_pend_d;
      fetch_addr_q <= fetch_addr_d;
      rd_v1_q      <= rd_v1_d;
      rd_v2_q      <= rd_v2_d;
      next_pix_q   <= next_pix_d;
      cur_pix_q    <= cur_pix_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      wr_ack_q     <= wr_ack_d;
      wr_err_q     <= wr_err_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_in;
      vsync_q      <= vsync_in;
    end
  end

  assign wr_ack             = wr_ack_q;
  assign wr_err             = wr_err_q;
  assign ram_addr           = ram_addr_q;
  assign ram_we             = ram_we_q;
  assign ram_wdata          = ram_wdata_q;
  assign {red, green, blue} = rgb_q;
  assign hsync              = hsync_q;
  assign vsync              = vsync_q;

endmodule
